serial_decrementer: RTL and testbench
=====================================

# serial_decrementer

Bit-serial decrementer that computes A − 1 over WIDTH clock cycles, LSB first, using one half-subtractor cell and a registered borrow. It is the down-counting counterpart of the team's ripple half-adder incrementer and sits wherever a counter value must step down without a full-width subtractor. A start/busy/done handshake frames each operation, and the result is held until the next operation completes.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand; captured on the accepting edge only
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  single-cycle completion pulse (DONE state)
- D  output  WIDTH  result A − 1 mod 2^WIDTH; registered and held
- B  output  1  final borrow; 1 only when A == 0 (underflow); registered and held

## Operation
- Internal state:
  - sreg[WIDTH-1:0] shift register
  - brw borrow flip-flop
  - cnt bit counter, width clog2(WIDTH+1)
  - FSM state
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:** when start = 1, load sreg ← A, brw ← 1 (the subtrahend 1 enters as the initial borrow), cnt ← 0, then go to SHIFT. When start = 0, remain in IDLE.
- **SHIFT:** each cycle, take the bit b = sreg[0] and compute:
  - diff = b ^ brw
  - brw ← ~b & brw
  - sreg ← {diff, sreg[WIDTH-1:1]}
  - cnt ← cnt + 1
- When cnt == WIDTH−1, the cycle processes the last bit and the FSM goes to DONE. On that edge, D ← the final shifted value and B ← the final borrow.
- **DONE:** done = 1 for exactly one cycle, then the FSM goes unconditionally to IDLE.
- start is ignored in SHIFT and DONE; it is not queued, and A is not re-sampled.
- D and B change only on the edge entering DONE. At all other times they hold the previous result.
- Arithmetic is modulo 2^WIDTH: A = 0 yields D = all-ones and B = 1. For any A ≠ 0, B = 0.
- Outputs are driven directly from registers or decoded from the FSM state (busy = state==SHIFT, done = state==DONE). There is no combinational path from an input to any output.

## Timing
- Reset (rst_n = 0, asynchronous assertion): state = IDLE, busy = 0, done = 0, D = 0, B = 0, sreg = 0, brw = 0, cnt = 0. Deassertion is synchronous to clk; the bench releases rst_n away from the clock edge.
- Start is accepted at edge E0 (IDLE and start = 1).
  - busy is high in the WIDTH cycles following E0.
  - The FSM enters DONE at edge E_WIDTH; done is high and D/B are valid in the cycle after E_WIDTH.
  - The FSM returns to IDLE at E_(WIDTH+1).
- Latency: WIDTH+1 edges from accept to done. Minimum issue interval: WIDTH+2 cycles, because start is first accepted again at E_(WIDTH+2).
- Reset mid-operation (SHIFT or DONE): the operation is aborted immediately. No done pulse is produced, D and B are cleared, and the next accepted start operates normally.
- start held high continuously: a new operation is accepted every WIDTH+2 cycles, and each operation produces exactly one done pulse.
- A changing during SHIFT has no effect on the result in progress.

## Test plan
- **Basic decrement:** reset, then A = 4'd5 with a one-cycle start pulse → busy high for 4 cycles, done pulses once 5 edges after accept, D = 4'd4, B = 0.
- **Underflow wrap:** A = 4'd0 → D = 4'd15, B = 1. Borrow-chain case: A = 4'd8 → D = 4'd7, B = 0.
- **Exhaustive:** all 16 values of A, issued back-to-back with start held high → 16 done pulses spaced 6 cycles apart, D = (A − 1) mod 16, B = (A == 0). Compare against a reference model.
- **Start ignored while busy:** start with A = 4'd9, then pulse start with A = 4'd2 during SHIFT and again during DONE → a single done pulse with D = 4'd8. No second operation starts until start is reasserted in IDLE.
- **Reset mid-operation:** start with A = 4'd12, drive rst_n low in the 2nd SHIFT cycle → busy, done, D, and B are immediately 0 and no done pulse follows. After release, start with A = 4'd1 → D = 4'd0, B = 0.
- **Hold behaviour:** after the result for A = 4'd3 (D = 2), toggle A with start low for 10 cycles → D stays 2, B stays 0, done stays 0.

Source files
------------

// File: rtl/serial_decrementer.sv
// Bit-serial A-1: one half-subtractor cell and a registered borrow, LSB first,
// framed by a start/busy/done handshake; the result is held until the next completion.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; operand captured on the accepting edge
//   S_SHIFT | one bit per cycle through the half-subtractor (busy = 1)
//   S_DONE  | single-cycle completion pulse (done = 1), D/B just updated
module serial_decrementer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             B
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic             bit_in, diff, brw_nxt;
   logic [WIDTH-1:0] sreg_nxt;

   // The subtrahend 1 enters as the initial borrow, so only a half-subtractor is needed.
   assign bit_in   = sreg[0];
   assign diff     = bit_in ^ brw;
   assign brw_nxt  = ~bit_in & brw;
   assign sreg_nxt = {diff, sreg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         brw  <= 1'b0;
         cnt  <= '0;
         D    <= '0;
         B    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sreg <= A;
                  brw  <= 1'b1;
                  cnt  <= '0;
               end
            end
            S_SHIFT: begin
               sreg <= sreg_nxt;
               brw  <= brw_nxt;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  D <= sreg_nxt;
                  B <= brw_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == S_SHIFT);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_decrementer.sv
// Self-checking bench for serial_decrementer: vector table, random operands against
// an arithmetic reference, and hand-written handshake/reset/hold sequences.
module tb_serial_decrementer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic         busy, done, b;
   logic [W-1:0] d;

   int n_checks = 0;
   int n_fail   = 0;

   serial_decrementer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a),
      .busy(busy), .done(done), .D(d), .B(b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] exp_d;
      logic         exp_b;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_d(input int av);
      return W'((av + (1 << W) - 1) % (1 << W));
   endfunction

   function automatic logic ref_b(input int av);
      return (av == 0);
   endfunction

   // Issue one operation with a single-cycle start pulse; all sampling on falling edges.
   task automatic op(input logic [W-1:0] av, output logic [W-1:0] od, output logic ob,
                     output int lat, output int nbusy);
      @(negedge clk);
      a = av;
      start = 1'b1;
      lat = -1;
      nbusy = 0;
      for (int k = 1; k <= 4 * W; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            lat = k;
            break;
         end
      end
      od = d;
      ob = b;
      @(negedge clk);
      chk("done_single_pulse", done, 0);
   endtask

   initial begin
      vec_t         vecs[5];
      logic [W-1:0] od;
      logic         ob;
      int           lat, nbusy;
      logic [W-1:0] expq[$];
      int           ndone, last_done, prev_busy, idx, nb;
      logic [W-1:0] av;

      vecs[0] = '{a: 4'd5,  exp_d: 4'd4,  exp_b: 1'b0};
      vecs[1] = '{a: 4'd0,  exp_d: 4'd15, exp_b: 1'b1};
      vecs[2] = '{a: 4'd8,  exp_d: 4'd7,  exp_b: 1'b0};
      vecs[3] = '{a: 4'd15, exp_d: 4'd14, exp_b: 1'b0};
      vecs[4] = '{a: 4'd1,  exp_d: 4'd0,  exp_b: 1'b0};

      // reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d", d, 0);
      chk("rst_b", b, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 5; i++) begin
         op(vecs[i].a, od, ob, lat, nbusy);
         chk("vec_d", od, vecs[i].exp_d);
         chk("vec_b", ob, vecs[i].exp_b);
         chk("vec_latency", lat, W + 1);
         chk("vec_busy_cycles", nbusy, W);
      end

      // random operands against the arithmetic reference
      for (int i = 0; i < 20; i++) begin
         av = W'($urandom_range(0, (1 << W) - 1));
         op(av, od, ob, lat, nbusy);
         chk("rand_d", od, ref_d(av));
         chk("rand_b", ob, ref_b(av));
         chk("rand_latency", lat, W + 1);
      end

      // exhaustive, back-to-back with start held high
      @(negedge clk);
      idx = 0;
      a = W'(idx);
      start = 1'b1;
      ndone = 0;
      last_done = -1;
      prev_busy = 0;
      for (int k = 1; k <= 16 * (W + 2) + 20 && ndone < 16; k++) begin
         @(negedge clk);
         if (busy && !prev_busy) begin
            expq.push_back(a);
            idx++;
            if (idx == 16) start = 1'b0;
            else a = W'(idx);
         end
         prev_busy = busy;
         if (done) begin
            if (expq.size() == 0) begin
               chk("exh_unexpected_done", 1, 0);
            end else begin
               av = expq.pop_front();
               chk("exh_d", d, ref_d(av));
               chk("exh_b", b, ref_b(av));
            end
            if (last_done >= 0) chk("exh_spacing", k - last_done, W + 2);
            last_done = k;
            ndone++;
         end
      end
      start = 1'b0;
      chk("exh_done_count", ndone, 16);
      repeat (3) @(negedge clk);

      // start ignored in SHIFT and DONE
      @(negedge clk);
      a = 4'd9;
      start = 1'b1;
      ndone = 0;
      nb = 0;
      od = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin
            ndone++;
            od = d;
         end
         start = (k == 2 || k == 5);
         a = 4'd2;
      end
      chk("ign_done_count", ndone, 1);
      chk("ign_d", od, 4'd8);
      chk("ign_busy_cycles", nb, W);

      // reset mid-operation
      @(negedge clk);
      a = 4'd12;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_d", d, 0);
      chk("midrst_b", b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("midrst_no_activity", ndone, 0);
      op(4'd1, od, ob, lat, nbusy);
      chk("postrst_d", od, 4'd0);
      chk("postrst_b", ob, 0);
      chk("postrst_latency", lat, W + 1);

      // hold behaviour
      op(4'd3, od, ob, lat, nbusy);
      chk("hold_first_d", od, 4'd2);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         a = W'($urandom);
         chk("hold_d", d, 4'd2);
         chk("hold_b", b, 0);
         chk("hold_done", done, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
